// File: rtl/rf_pkg.sv
// Shared defaults and state encoding for the pipelined integer register file.
package rf_pkg;

    localparam int unsigned XLEN_DEFAULT  = 32;
    localparam int unsigned NREGS_DEFAULT = 32;
    localparam bit          ZERO_REG_DEFAULT = 1'b1;

    typedef enum logic [0:0] {
        RF_INIT,
        RF_READY
    } rf_state_e;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy bits for hazard detection: set on issue, cleared on writeback or init.
// With RF_BYPASS_EN defined, a same-cycle writeback clears the reported busy combinationally.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int unsigned NREGS    = NREGS_DEFAULT,
    parameter bit          ZERO_REG = ZERO_REG_DEFAULT,
    localparam int unsigned AW      = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          init_clear,
    input  logic [AW-1:0] init_idx,
    input  logic          active,
    input  logic          ready,
    input  logic          issue_valid,
    input  logic [AW-1:0] issue_rd,
    input  logic          wb_valid,
    input  logic [AW-1:0] wb_rd,
    input  logic [AW-1:0] rs1_addr,
    input  logic [AW-1:0] rs2_addr,
    output logic          rs1_busy,
    output logic          rs2_busy
);

    logic [NREGS-1:0] busy_q, busy_d;
    logic             set_en, clr_en;

    assign set_en = active && issue_valid && !(ZERO_REG && issue_rd == '0);
    assign clr_en = active && wb_valid && !(ZERO_REG && wb_rd == '0);

    always_comb begin
        busy_d = busy_q;
        if (init_clear) begin
            busy_d[init_idx] = 1'b0;
        end else begin
            if (clr_en) busy_d[wb_rd] = 1'b0;
            // Set after clear: a new producer issuing alongside writeback stays outstanding.
            if (set_en) busy_d[issue_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        busy_q <= busy_d;
    end

    function automatic logic read_busy(input logic [AW-1:0] addr);
        logic b;
        b = ready && !(ZERO_REG && addr == '0) && busy_q[addr];
`ifdef RF_BYPASS_EN
        if (clr_en && wb_rd == addr) b = set_en && issue_rd == addr;
`endif
        return b;
    endfunction

    always_comb begin
        rs1_busy = read_busy(rs1_addr);
        rs2_busy = read_busy(rs2_addr);
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// Integer register file with two async reads, one writeback port, busy scoreboard and
// sequenced clear after reset. Define RF_BYPASS_EN for write-before-read forwarding.
module regfile_scoreboard
    import rf_pkg::*;
#(
    parameter int unsigned XLEN     = XLEN_DEFAULT,
    parameter int unsigned NREGS    = NREGS_DEFAULT,
    parameter bit          ZERO_REG = ZERO_REG_DEFAULT,
    localparam int unsigned AW      = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            reset,
    output logic            ready,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic            rs1_busy,
    output logic            rs2_busy,
    input  logic            issue_valid,
    input  logic [AW-1:0]   issue_rd,
    input  logic            wb_valid,
    input  logic [AW-1:0]   wb_rd,
    input  logic [XLEN-1:0] wb_data
);

    rf_state_e       state_q, state_d;
    logic [AW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] mem [NREGS];

    logic            init_clear;
    logic            active;
    logic            wb_fire;
    logic            mem_we;
    logic [AW-1:0]   mem_waddr;
    logic [XLEN-1:0] mem_wdata;

    assign ready      = (state_q == RF_READY);
    assign init_clear = (state_q == RF_INIT);
    // Traffic is dropped on the edge that samples reset, even if still READY.
    assign active     = ready && !reset;
    assign wb_fire    = active && wb_valid && !(ZERO_REG && wb_rd == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RF_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            RF_INIT: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == AW'(NREGS - 1)) state_d = RF_READY;
            end
            RF_READY: begin
                state_d = RF_READY;
            end
            default: begin
                state_d = RF_INIT;
            end
        endcase
    end

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = wb_rd;
        mem_wdata = wb_data;
        if (init_clear) begin
            mem_we    = 1'b1;
            mem_waddr = cnt_q;
            mem_wdata = '0;
        end else if (wb_fire) begin
            mem_we = 1'b1;
        end
    end

    // No reset on the array; the init sequence clears it one entry per cycle.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    function automatic logic [XLEN-1:0] read_data(input logic [AW-1:0] addr);
        logic [XLEN-1:0] d;
        d = (ready && !(ZERO_REG && addr == '0)) ? mem[addr] : '0;
`ifdef RF_BYPASS_EN
        if (wb_fire && wb_rd == addr) d = wb_data;
`endif
        return d;
    endfunction

    always_comb begin
        rs1_data = read_data(rs1_addr);
        rs2_data = read_data(rs2_addr);
    end

    rf_scoreboard #(
        .NREGS    (NREGS),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk         (clk),
        .init_clear  (init_clear),
        .init_idx    (cnt_q),
        .active      (active),
        .ready       (ready),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .rs1_addr    (rs1_addr),
        .rs2_addr    (rs2_addr),
        .rs1_busy    (rs1_busy),
        .rs2_busy    (rs2_busy)
    );

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed self-checking bench for regfile_scoreboard (XLEN=32, NREGS=32, ZERO_REG=1).
module tb_regfile_scoreboard;

`ifdef RF_BYPASS_EN
    localparam bit Byp = 1'b1;
`else
    localparam bit Byp = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        ready;
    logic [4:0]  rs1_addr, rs2_addr;
    logic [31:0] rs1_data, rs2_data;
    logic        rs1_busy, rs2_busy;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    int errors = 0;
    int checks = 0;

    regfile_scoreboard #(
        .XLEN     (32),
        .NREGS    (32),
        .ZERO_REG (1'b1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ready       (ready),
        .rs1_addr    (rs1_addr),
        .rs2_addr    (rs2_addr),
        .rs1_data    (rs1_data),
        .rs2_data    (rs2_data),
        .rs1_busy    (rs1_busy),
        .rs2_busy    (rs2_busy),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        issue_valid = 1'b0;
        wb_valid    = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        idle();
        issue_rd = '0; wb_rd = '0; wb_data = '0;
        rs1_addr = '0; rs2_addr = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        checks++;
        if (ready !== 1'b0) begin
            errors++; $display("FAIL reset_ready: got %b expected 0", ready);
        end
        for (int i = 1; i <= 32; i++) begin
            step();
            checks++;
            if (ready !== (i == 32)) begin
                errors++; $display("FAIL init_ready edge %0d: got %b expected %b", i, ready, i == 32);
            end
        end
        for (int a = 0; a < 32; a++) begin
            rs1_addr = 5'(a);
            rs2_addr = 5'(31 - a);
            #1;
            checks++;
            if ({rs1_data, rs2_data, rs1_busy, rs2_busy} !== 66'd0) begin
                errors++;
                $display("FAIL init_clear addr %0d: got %h/%h busy %b/%b expected 0/0 busy 0/0",
                         a, rs1_data, rs2_data, rs1_busy, rs2_busy);
            end
        end
    endtask

    task automatic test_write;
        rs1_addr = 5'd5;
        wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEAD_BEEF;
        #1;
        checks++;
        if (rs1_data !== (Byp ? 32'hDEAD_BEEF : 32'h0)) begin
            errors++; $display("FAIL write_same_cycle: got %h expected %h",
                               rs1_data, Byp ? 32'hDEAD_BEEF : 32'h0);
        end
        step();
        idle();
        #1;
        checks++;
        if (rs1_data !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL write_next_cycle: got %h expected deadbeef", rs1_data);
        end
        checks++;
        if (rs1_busy !== 1'b0) begin
            errors++; $display("FAIL wb_not_busy: got %b expected 0", rs1_busy);
        end
    endtask

    task automatic test_zero_reg;
        rs2_addr = 5'd0;
        wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 32'h1234;
        issue_valid = 1'b1; issue_rd = 5'd0;
        #1;
        checks++;
        if (rs2_data !== 32'h0) begin
            errors++; $display("FAIL zero_same_cycle: got %h expected 0", rs2_data);
        end
        step();
        idle();
        #1;
        checks++;
        if (rs2_data !== 32'h0) begin
            errors++; $display("FAIL zero_data: got %h expected 0", rs2_data);
        end
        checks++;
        if (rs2_busy !== 1'b0) begin
            errors++; $display("FAIL zero_busy: got %b expected 0", rs2_busy);
        end
    endtask

    task automatic test_busy;
        rs1_addr = 5'd7;
        issue_valid = 1'b1; issue_rd = 5'd7;
        #1;
        checks++;
        if (rs1_busy !== 1'b0) begin
            errors++; $display("FAIL busy_before_edge: got %b expected 0", rs1_busy);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            idle();
            #1;
            checks++;
            if (rs1_busy !== 1'b1) begin
                errors++; $display("FAIL busy_held cycle %0d: got %b expected 1", i, rs1_busy);
            end
        end
        wb_valid = 1'b1; wb_rd = 5'd7; wb_data = 32'h77;
        #1;
        checks++;
        if (rs1_busy !== !Byp) begin
            errors++; $display("FAIL busy_wb_cycle: got %b expected %b", rs1_busy, !Byp);
        end
        step();
        idle();
        #1;
        checks++;
        if ({rs1_busy, rs1_data} !== {1'b0, 32'h77}) begin
            errors++; $display("FAIL busy_cleared: got busy %b data %h expected busy 0 data 77",
                               rs1_busy, rs1_data);
        end
        // Same-cycle issue and writeback: set wins.
        rs2_addr = 5'd9;
        issue_valid = 1'b1; issue_rd = 5'd9;
        wb_valid = 1'b1; wb_rd = 5'd9; wb_data = 32'h99;
        #1;
        checks++;
        if (rs2_busy !== Byp) begin
            errors++; $display("FAIL set_wins_same_cycle: got %b expected %b", rs2_busy, Byp);
        end
        step();
        idle();
        #1;
        checks++;
        if ({rs2_busy, rs2_data} !== {1'b1, 32'h99}) begin
            errors++; $display("FAIL set_wins: got busy %b data %h expected busy 1 data 99",
                               rs2_busy, rs2_data);
        end
        wb_valid = 1'b1; wb_rd = 5'd9; wb_data = 32'h9A;
        step();
        idle();
        #1;
        checks++;
        if ({rs2_busy, rs2_data} !== {1'b0, 32'h9A}) begin
            errors++; $display("FAIL busy9_clear: got busy %b data %h expected busy 0 data 9a",
                               rs2_busy, rs2_data);
        end
    endtask

    task automatic test_back_to_back;
        wb_valid = 1'b1; wb_rd = 5'd10; wb_data = 32'hA5A5_0001;
        step();
        wb_rd = 5'd11; wb_data = 32'h5A5A_0002;
        step();
        idle();
        rs1_addr = 5'd10; rs2_addr = 5'd11;
        #1;
        checks++;
        if ({rs1_data, rs2_data} !== {32'hA5A5_0001, 32'h5A5A_0002}) begin
            errors++; $display("FAIL back_to_back: got %h/%h expected a5a50001/5a5a0002",
                               rs1_data, rs2_data);
        end
    endtask

    task automatic test_reset_mid;
        rs1_addr = 5'd3; rs2_addr = 5'd5;
        issue_valid = 1'b1; issue_rd = 5'd3;
        step();
        idle();
        #1;
        checks++;
        if (rs1_busy !== 1'b1) begin
            errors++; $display("FAIL mid_busy_set: got %b expected 1", rs1_busy);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        checks++;
        if (ready !== 1'b0) begin
            errors++; $display("FAIL mid_ready_drop: got %b expected 0", ready);
        end
        checks++;
        if (rs2_data !== 32'h0) begin
            errors++; $display("FAIL init_read_gate: got %h expected 0", rs2_data);
        end
        for (int i = 1; i <= 32; i++) begin
            step();
            checks++;
            if (ready !== (i == 32)) begin
                errors++; $display("FAIL mid_init_ready edge %0d: got %b expected %b",
                                   i, ready, i == 32);
            end
        end
        checks++;
        if ({rs1_busy, rs1_data, rs2_data} !== 65'd0) begin
            errors++; $display("FAIL mid_cleared: got busy %b data %h/%h expected 0 0/0",
                               rs1_busy, rs1_data, rs2_data);
        end
    endtask

    task automatic test_no_bypass;
        rs1_addr = 5'd4;
        wb_valid = 1'b1; wb_rd = 5'd4; wb_data = 32'h55;
        #1;
        checks++;
        if (rs1_data !== (Byp ? 32'h55 : 32'h0)) begin
            errors++; $display("FAIL wb4_same_cycle: got %h expected %h",
                               rs1_data, Byp ? 32'h55 : 32'h0);
        end
        step();
        idle();
        #1;
        checks++;
        if (rs1_data !== 32'h55) begin
            errors++; $display("FAIL wb4_next_cycle: got %h expected 55", rs1_data);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_zero_reg();
        test_busy();
        test_back_to_back();
        test_reset_mid();
        test_no_bypass();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

Parametrised integer register file for the pipelined RISC-V core: two asynchronous read ports, one synchronous writeback port, and a per-register busy scoreboard for hazard detection. Storage is cleared by a sequenced init state machine, one entry per cycle, so the array maps to RAM-style storage without a wide reset. It sits between decode (reads, issue) and writeback, and replaces the single-cycle register file in the pipelined design.

## Interface
- XLEN, 32, data width in bits
- NREGS, 32, number of registers; power of two, at least 2
- ZERO_REG, 1, if 1 register 0 is hardwired to zero; writes and issues to it are ignored
- AW (localparam), $clog2(NREGS), register address width

- clk  in  1  clock
- reset  in  1  synchronous, active-high
- ready  out  1  high when init is done and the block accepts traffic
- rs1_addr, rs2_addr  in  AW  read addresses
- rs1_data, rs2_data  out  XLEN  read data, combinational
- rs1_busy, rs2_busy  out  1  scoreboard bit of the addressed register, combinational
- issue_valid  in  1  an instruction writing issue_rd has issued
- issue_rd  in  AW  destination register to mark busy
- wb_valid  in  1  writeback strobe
- wb_rd  in  AW  writeback destination
- wb_data  in  XLEN  writeback data

## Operation
- States:
  - INIT: entered on reset. On every cycle in INIT, the block writes zero to reg[cnt], clears busy[cnt], and increments cnt.
  - When cnt == NREGS-1, the next state is READY.
  - READY holds until reset.
- In INIT:
  - ready is 0.
  - rs*_data read 0 and rs*_busy read 0.
  - issue and wb inputs are ignored.
- READY, write: wb_valid && !(ZERO_REG && wb_rd==0) writes reg[wb_rd] <= wb_data at the clock edge.
- READY, scoreboard:
  - issue_valid sets busy[issue_rd].
  - wb_valid clears busy[wb_rd].
  - Addresses equal to 0 are ignored when ZERO_REG=1.
- Simultaneous issue and wb to the same rd: set wins. The new producer is outstanding, so busy stays 1.
- Issue to a register that is already busy: busy stays 1. No counting is done; the pipeline allows only one outstanding producer per rd.
- Wb to a register that is not busy: data is written and busy stays 0. This case is legal.
- Reads with ZERO_REG=1 and address 0 return 0 data and busy 0.
- Reset mid-operation: the block returns to INIT with cnt=0, ready drops the cycle after reset is sampled, and all pending busy bits are discarded.

## Timing
- After reset: ready=0, state=INIT, cnt=0. Register contents are undefined until cleared.
- ready rises exactly NREGS clock edges after the last edge at which reset was sampled high.
- Read latency is 0 (combinational from address and storage).
- Written data is visible on the reads from the cycle after the wb edge, or in the same cycle when bypass is enabled.
- Busy set/clear becomes visible the cycle after the edge. The bypass described below also applies to the busy clear.

## Configuration
- RF_BYPASS_EN defined:
  - A read whose address matches wb_rd while wb_valid is high (and the address is not a hardwired zero) returns wb_data combinationally.
  - The corresponding rs*_busy reads 0 unless issue_valid with issue_rd == that address is also high in the same cycle.
  - This gives a write-before-read register file.
- RF_BYPASS_EN undefined:
  - Reads return the stored value only.
  - Busy shows the stored bit.
  - The write is observed one cycle later.

## Structure
- Package rf_pkg holds:
  - XLEN/NREGS defaults
  - the state enum {RF_INIT, RF_READY}
  - the ZERO_REG default
- Sub-module rf_scoreboard holds the busy vector, its set/clear/init-clear logic, and the busy read muxes. It is parametrised by NREGS and ZERO_REG.
- The top level holds the storage array, the init counter/FSM, the read muxes, and the bypass.

## Test plan
- Reset held 3 cycles, then released, with NREGS=32: ready=0 for exactly 32 edges, then 1; all 32 reads return 0 and busy=0.
- After ready, wb_valid, wb_rd=5, wb_data=0xDEADBEEF: rs1_addr=5 reads 0xDEADBEEF on the next cycle. With RF_BYPASS_EN it reads the value in the same cycle.
- Write 0x1234 to register 0 with ZERO_REG=1: rs2_addr=0 reads 0. Issue to rd=0 leaves rs2_busy=0.
- issue rd=7, then 2 idle cycles, then wb rd=7: rs1_busy=1 for those cycles and 0 after the wb edge. Issue and wb to rd=9 in the same cycle leave busy[9]=1.
- Issue rd=3, then assert reset for 1 cycle: ready=0 on the next cycle, busy[3]=0 once init completes, and ready returns 32 edges after reset.
- Without RF_BYPASS_EN, with wb rd=4 data=0x55 and rs1_addr=4 in the same cycle: old value 0 that cycle, 0x55 the next cycle.
